proc_sequencer: RTL and testbench

//  Drives the multicycle processor's DIN/Run/Done handshake from a program ROM. Fetches one 16-bit instruction per step,

---
 rtl/proc_sequencer_pkg.sv | 30 +++
 rtl/proc_sequencer_watchdog.sv | 30 +++
 rtl/proc_sequencer.sv | 129 ++++++++++++
 tb/tb_proc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/proc_sequencer_pkg.sv
// proc_sequencer_pkg: sequencer state encodings and proc opcode helpers. Rev 1.0
// SEQ_SINGLE_STEP_EN adds the PAUSE state encoding.
`default_nettype none

package proc_sequencer_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_ERROR = 3'd4
`ifdef SEQ_SINGLE_STEP_EN
      , S_PAUSE = 3'd5
`endif
   } seq_state_t;

   // Opcode lives in DIN[15:13]
   localparam logic [2:0] OP_MV  = 3'b000;
   localparam logic [2:0] OP_MVT = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;

   function automatic int unsigned proc_steps(input logic [2:0] op);
      return (op == OP_ADD || op == OP_SUB) ? 32'd3 : 32'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/proc_sequencer_watchdog.sv
// proc_sequencer_watchdog: 8-bit WAIT-state watchdog, expires at MAX-1. Rev 1.0
`default_nettype none

module proc_sequencer_watchdog #(
   parameter int MAX = 8
) (
   input  logic Clock,
   input  logic Resetn,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   logic [7:0] cnt;

   assign expire = (cnt == 8'(MAX - 1));

   // Holds at the expiry value so a late Done cannot see a wrapped count
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expire)
         cnt <= cnt + 8'd1;
   end

endmodule

`default_nettype wire

// File: rtl/proc_sequencer.sv
// proc_sequencer: ROM-driven Run/Done sequencer for the multicycle proc. Rev 1.0
// Optional macro SEQ_SINGLE_STEP_EN adds StepReq and a PAUSE state between instructions.
`default_nettype none

module proc_sequencer
   import proc_sequencer_pkg::*;
#(
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 16,
   parameter int WDOG_MAX = 8
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Halt,
   input  logic [ADDR_W-1:0] ProgLen,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic [DATA_W-1:0] MemData,
   output logic [DATA_W-1:0] DIN,
   output logic              Run,
   input  logic              Done,
`ifdef SEQ_SINGLE_STEP_EN
   input  logic              StepReq,
`endif
   output logic              Busy,
   output logic              Finished,
   output logic              Timeout,
   output logic [ADDR_W:0]   InstrCount
);

   localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

   seq_state_t        state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W:0]   count;
   logic [ADDR_W:0]   len;
   logic [ADDR_W:0]   count_inc;
   logic              wdog_expire;

   assign count_inc  = count + 1'b1;
   assign MemAddr    = pc;
   assign DIN        = MemData;
   assign InstrCount = count;

   proc_sequencer_watchdog #(
      .MAX (WDOG_MAX)
   ) u_wdog (
      .Clock  (Clock),
      .Resetn (Resetn),
      .clear  (state == S_ISSUE),
      .enable (state == S_WAIT),
      .expire (wdog_expire)
   );

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state    <= S_IDLE;
         pc       <= '0;
         count    <= '0;
         len      <= '0;
         Run      <= 1'b0;
         Busy     <= 1'b0;
         Finished <= 1'b0;
         Timeout  <= 1'b0;
      end else begin
         Run <= 1'b0;
         case (state)
            S_IDLE, S_ERROR: begin
               if (Start) begin
                  state    <= S_FETCH;
                  pc       <= '0;
                  count    <= '0;
                  len      <= (ProgLen == '0) ? FULL_LEN : {1'b0, ProgLen};
                  Finished <= 1'b0;
                  Timeout  <= 1'b0;
                  Busy     <= 1'b1;
               end
            end
            S_FETCH: begin
               state <= S_ISSUE;
               Run   <= 1'b1;
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               // Done takes priority over a same-cycle watchdog expiry
               if (Done) begin
                  count <= count_inc;
                  pc    <= pc + 1'b1;
                  if (count_inc == len) begin
                     state    <= S_IDLE;
                     Finished <= 1'b1;
                     Busy     <= 1'b0;
                  end else if (Halt) begin
                     state <= S_IDLE;
                     Busy  <= 1'b0;
                  end else begin
`ifdef SEQ_SINGLE_STEP_EN
                     state <= S_PAUSE;
`else
                     state <= S_FETCH;
`endif
                  end
               end else if (wdog_expire) begin
                  state   <= S_ERROR;
                  Timeout <= 1'b1;
                  Busy    <= 1'b0;
               end
            end
`ifdef SEQ_SINGLE_STEP_EN
            S_PAUSE: begin
               if (Halt) begin
                  state <= S_IDLE;
                  Busy  <= 1'b0;
               end else if (StepReq) begin
                  state <= S_FETCH;
               end
            end
`endif
            default: begin
               state <= S_IDLE;
               Busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: scoreboard bench with a synchronous ROM and a proc Done model.
`default_nettype none

module tb_proc_sequencer;
   import proc_sequencer_pkg::*;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 16;

   logic              Clock = 1'b0;
   logic              Resetn = 1'b0;
   logic              Start = 1'b0;
   logic              Halt = 1'b0;
   logic [ADDR_W-1:0] ProgLen = '0;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemData = '0;
   logic [DATA_W-1:0] DIN;
   logic              Run;
   logic              Done = 1'b0;
   logic              Busy;
   logic              Finished;
   logic              Timeout;
   logic [ADDR_W:0]   InstrCount;
`ifdef SEQ_SINGLE_STEP_EN
   logic              StepReq = 1'b0;
`endif

   proc_sequencer #(
      .ADDR_W   (ADDR_W),
      .DATA_W   (DATA_W),
      .WDOG_MAX (8)
   ) dut (
      .Clock      (Clock),
      .Resetn     (Resetn),
      .Start      (Start),
      .Halt       (Halt),
      .ProgLen    (ProgLen),
      .MemAddr    (MemAddr),
      .MemData    (MemData),
      .DIN        (DIN),
      .Run        (Run),
      .Done       (Done),
`ifdef SEQ_SINGLE_STEP_EN
      .StepReq    (StepReq),
`endif
      .Busy       (Busy),
      .Finished   (Finished),
      .Timeout    (Timeout),
      .InstrCount (InstrCount)
   );

   always #5 Clock = ~Clock;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] din;
   } issue_t;

   logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
   issue_t            exp_q[$];
   int                tests = 0;
   int                fails = 0;
   bit                proc_never = 1'b0;

   // Synchronous ROM, one cycle read latency
   always @(posedge Clock) MemData <= rom[MemAddr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_issue(input int pc);
      issue_t e;
      e.pc  = ADDR_W'(pc);
      e.din = rom[pc];
      exp_q.push_back(e);
   endtask

   task automatic pulse_start(input logic [ADDR_W-1:0] len);
      @(negedge Clock);
      ProgLen = len;
      Start   = 1'b1;
      @(negedge Clock);
      Start   = 1'b0;
   endtask

   // sel: 0 Finished, 1 Run, 2 !Busy, 3 Timeout; cycles = negedges waited
   task automatic wait_sig(input int sel, input int limit, input string name, output int cycles);
      bit hit;
      hit    = 1'b0;
      cycles = 0;
      while (!hit && cycles < limit) begin
         @(negedge Clock);
         cycles++;
         case (sel)
            0:       hit = Finished;
            1:       hit = Run;
            2:       hit = !Busy;
            default: hit = Timeout;
         endcase
      end
      if (!hit) begin
         tests++;
         fails++;
         $display("FAIL %s: wait expired after %0d cycles, required event not seen", name, cycles);
      end
   endtask

   // Proc model: Done pulses in the Nth WAIT cycle after Run
   initial begin
      int pending;
      pending = 0;
      forever begin
         @(negedge Clock);
         Done = 1'b0;
         if (!Resetn) begin
            pending = 0;
         end else if (pending > 0) begin
            pending--;
            if (pending == 0) Done = 1'b1;
         end else if (Run && !proc_never) begin
            pending = int'(proc_steps(DIN[15:13]));
         end
      end
   end

   // Scoreboard monitor
   initial begin
      issue_t e;
      forever begin
         @(negedge Clock);
         if (Resetn && Run) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_run: got Run at pc %0d, required no issue", MemAddr);
            end else begin
               e = exp_q.pop_front();
               check("issue_pc", 32'(MemAddr), 32'(e.pc));
               check("issue_din", 32'(DIN), 32'(e.din));
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1, "bench timeout");
   end

   initial begin
      int cyc;
      int bad;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         logic [2:0] op;
         op = (i % 3 == 1) ? OP_ADD : ((i % 7 == 6) ? OP_SUB : OP_MV);
         rom[i] = {op, 13'(i * 37 + 5)};
      end

      // Reset state
      repeat (2) @(negedge Clock);
      check("rst_run", 32'(Run), 0);
      check("rst_busy", 32'(Busy), 0);
      check("rst_flags", {30'd0, Finished, Timeout}, 0);
      check("rst_count", 32'(InstrCount), 0);
      check("rst_addr", 32'(MemAddr), 0);
      Resetn = 1'b1;
      repeat (2) @(negedge Clock);

      // ProgLen=3: mv, add, mv -> 3 + 5 + 3 cycles
      push_issue(0); push_issue(1); push_issue(2);
      pulse_start(5'd3);
      check("p3_busy", 32'(Busy), 1);
      wait_sig(0, 40, "p3_wait", cyc);
      check("p3_finish_cycle", 32'(cyc), 11);
      check("p3_count", 32'(InstrCount), 3);
      check("p3_busy_end", 32'(Busy), 0);
      check("p3_pc", 32'(MemAddr), 3);

      // ProgLen=0 -> full 32 instructions, PC wraps; a Start mid-run is ignored
      for (int i = 0; i < 32; i++) push_issue(i);
      pulse_start(5'd0);
      check("p0_clear_fin", 32'(Finished), 0);
      repeat (20) @(negedge Clock);
      pulse_start(5'd1);
      wait_sig(0, 400, "p0_wait", cyc);
      check("p0_count", 32'(InstrCount), 32);
      check("p0_pc_wrap", 32'(MemAddr), 0);

      // Watchdog: Done never comes
      proc_never = 1'b1;
      push_issue(0);
      pulse_start(5'd4);
      wait_sig(1, 10, "wd_run", cyc);
      wait_sig(3, 30, "wd_wait", cyc);
      check("wd_wait_cycles", 32'(cyc), 9);
      check("wd_busy", 32'(Busy), 0);
      check("wd_count", 32'(InstrCount), 0);
      check("wd_fin", 32'(Finished), 0);
      proc_never = 1'b0;
      push_issue(0);
      pulse_start(5'd1);
      check("wd_clear", 32'(Timeout), 0);
      check("wd_restart_busy", 32'(Busy), 1);
      wait_sig(0, 20, "wd_restart", cyc);
      check("wd_restart_count", 32'(InstrCount), 1);

      // Halt during 2nd instruction's WAIT
      push_issue(0); push_issue(1);
      pulse_start(5'd5);
      wait_sig(1, 10, "halt_run0", cyc);
      wait_sig(1, 10, "halt_run1", cyc);
      @(negedge Clock);
      Halt = 1'b1;
      wait_sig(2, 20, "halt_idle", cyc);
      Halt = 1'b0;
      check("halt_count", 32'(InstrCount), 2);
      check("halt_fin", 32'(Finished), 0);
      check("halt_pc", 32'(MemAddr), 2);
      repeat (4) @(negedge Clock);
      check("halt_stays_idle", 32'(Busy), 0);

      // Asynchronous reset in WAIT with PC=3
      for (int i = 0; i < 4; i++) push_issue(i);
      pulse_start(5'd5);
      for (int i = 0; i < 4; i++) wait_sig(1, 10, "rstw_run", cyc);
      @(negedge Clock);
      check("rstw_pre_pc", 32'(MemAddr), 3);
      Resetn = 1'b0;
      #1;
      check("rstw_busy", 32'(Busy), 0);
      check("rstw_pc", 32'(MemAddr), 0);
      check("rstw_count", 32'(InstrCount), 0);
      check("rstw_flags", {30'd0, Finished, Timeout}, 0);
      bad = 0;
      repeat (3) begin
         @(negedge Clock);
         if (Run || Busy) bad++;
      end
      Resetn = 1'b1;
      repeat (3) begin
         @(negedge Clock);
         if (Run || Busy) bad++;
      end
      check("rstw_quiet", 32'(bad), 0);

`ifdef SEQ_SINGLE_STEP_EN
      // Single step: parks in PAUSE after each instruction
      push_issue(0); push_issue(1);
      pulse_start(5'd2);
      wait_sig(1, 10, "ss_run0", cyc);
      repeat (2) @(negedge Clock);
      check("ss_count1", 32'(InstrCount), 1);
      bad = 0;
      repeat (10) begin
         @(negedge Clock);
         if (Run || !Busy || MemAddr != 5'd1) bad++;
      end
      check("ss_pause", 32'(bad), 0);
      StepReq = 1'b1;
      @(negedge Clock);
      StepReq = 1'b0;
      wait_sig(0, 20, "ss_finish", cyc);
      check("ss_count2", 32'(InstrCount), 2);
`endif

      repeat (3) @(negedge Clock);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
